// File: rtl/tt_um_hoene_protocol_pkg.sv
// Shared definitions for the Manchester LED protocol blocks:
// encoder state encoding, sync length and Manchester polarity.
package tt_um_hoene_protocol_pkg;

    // Encoder frame states, in transmission order.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SYNC_H = 3'd1,
        SYNC_L = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        GAP    = 3'd5
    } enc_state_t;

    // Sync violation: this many half-bits high, then this many low.
    localparam int SYNC_HALF_BITS = 3;

    // Line level during the first half of a bit; the second half is the bit value.
    localparam logic MAN_ONE_FIRST  = 1'b0;
    localparam logic MAN_ZERO_FIRST = 1'b1;

    // First-half line level for a given bit value.
    function automatic logic man_first_half(input logic bit_v);
        return bit_v ? MAN_ONE_FIRST : MAN_ZERO_FIRST;
    endfunction

endpackage

// File: rtl/tt_um_hoene_manchester_encoder_if.sv
// Transmit word handshake into the Manchester encoder.
// Handshake: a word transfers on a rising clk edge where tx_valid and tx_ready
// are both high; tx_data is sampled only at that edge. tx_valid seen while
// tx_ready is low is dropped, never queued. tx_ready is a registered output.
interface tt_um_hoene_manchester_encoder_if #(
    parameter int FRAME_BITS = 24
);
    logic [FRAME_BITS-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/tt_um_hoene_half_bit_timer.sv
// Half-bit timer: wrapping counter 0..HALF_PERIOD-1. tick marks the last
// cycle of a half-bit, pre_tick the cycle before it. clear restarts a half-bit.
module tt_um_hoene_half_bit_timer #(
    parameter int HALF_PERIOD = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick,
    output logic pre_tick
);
    localparam logic [5:0] LAST = 6'(HALF_PERIOD - 1);
    localparam logic [5:0] PRE  = 6'(HALF_PERIOD - 2);

    logic [5:0] r_cnt;

    // Count cycles within the current half-bit, wrapping at the last one.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_cnt <= 6'd0;
        end else if (r_cnt == LAST) begin
            r_cnt <= 6'd0;
        end else begin
            r_cnt <= r_cnt + 6'd1;
        end
    end

    assign tick     = (r_cnt == LAST);
    assign pre_tick = (r_cnt == PRE);
endmodule

// File: rtl/tt_um_hoene_manchester_encoder.sv
// Manchester LED protocol transmitter: sync violation, MSB-first Manchester
// data, optional even parity bit, then an idle gap with the line low.
// Optional feature: define TT_HOENE_MANCHESTER_ENC_PARITY_EN to send the parity bit.
module tt_um_hoene_manchester_encoder
    import tt_um_hoene_protocol_pkg::*;
#(
    parameter int FRAME_BITS  = 24,
    parameter int HALF_PERIOD = 8,
    parameter int GAP_BITS    = 2
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    tt_um_hoene_manchester_encoder_if.slave        tx_if,
    output logic                                   out,
    output logic                                   out_clk,
    output logic                                   out_data,
    output logic                                   busy,
    output enc_state_t                             dbg_state
);
    localparam int         MSB       = FRAME_BITS - 1;
    localparam logic [4:0] LAST_SYNC = 5'(SYNC_HALF_BITS - 1);
    localparam logic [4:0] LAST_GAP  = 5'(2 * GAP_BITS - 1);
    localparam logic [4:0] FIRST_BIT = 5'(FRAME_BITS - 1);

    enc_state_t            r_state;
    logic [FRAME_BITS-1:0] r_shreg;
    logic [4:0]            r_bit_cnt;
    logic [4:0]            r_half_idx;
    logic                  r_second;
    logic                  r_out;
    logic                  r_out_clk;
    logic                  r_out_data;
    logic                  r_busy;
    logic                  r_tx_ready;
`ifdef TT_HOENE_MANCHESTER_ENC_PARITY_EN
    logic                  r_parity;
`endif

    logic                  w_tick;
    logic                  w_pre_tick;
    logic                  w_hs;
    logic [FRAME_BITS-1:0] w_shreg_next;

    assign w_hs         = tx_if.tx_valid & r_tx_ready;
    assign w_shreg_next = r_shreg << 1;

    tt_um_hoene_half_bit_timer #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (w_hs),
        .tick    (w_tick),
        .pre_tick(w_pre_tick)
    );

    // Frame sequencer: every output is a register updated on half-bit ticks.
    // tx_ready rises in the final cycle of the gap so a held tx_valid is taken
    // on the very edge the gap ends, keeping back-to-back frames exactly one
    // frame length apart without stretching the idle gap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_shreg    <= '0;
            r_bit_cnt  <= 5'd0;
            r_half_idx <= 5'd0;
            r_second   <= 1'b0;
            r_out      <= 1'b0;
            r_out_clk  <= 1'b0;
            r_out_data <= 1'b0;
            r_busy     <= 1'b0;
            r_tx_ready <= 1'b0;
`ifdef TT_HOENE_MANCHESTER_ENC_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_out_clk <= 1'b0;
            if (w_hs) begin
                r_state    <= SYNC_H;
                r_shreg    <= tx_if.tx_data;
                r_half_idx <= 5'd0;
                r_out      <= 1'b1;
                r_busy     <= 1'b1;
                r_tx_ready <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_out      <= 1'b0;
                        r_busy     <= 1'b0;
                        r_tx_ready <= 1'b1;
                    end
                    SYNC_H: begin
                        if (w_tick) begin
                            if (r_half_idx == LAST_SYNC) begin
                                r_state    <= SYNC_L;
                                r_half_idx <= 5'd0;
                                r_out      <= 1'b0;
                            end else begin
                                r_half_idx <= r_half_idx + 5'd1;
                            end
                        end
                    end
                    SYNC_L: begin
                        if (w_tick) begin
                            if (r_half_idx == LAST_SYNC) begin
                                r_state   <= DATA;
                                r_second  <= 1'b0;
                                r_bit_cnt <= FIRST_BIT;
                                r_out     <= man_first_half(r_shreg[MSB]);
`ifdef TT_HOENE_MANCHESTER_ENC_PARITY_EN
                                r_parity  <= 1'b0;
`endif
                            end else begin
                                r_half_idx <= r_half_idx + 5'd1;
                            end
                        end
                    end
                    DATA: begin
                        if (w_tick) begin
                            if (!r_second) begin
                                r_second   <= 1'b1;
                                r_out      <= r_shreg[MSB];
                                r_out_clk  <= 1'b1;
                                r_out_data <= r_shreg[MSB];
`ifdef TT_HOENE_MANCHESTER_ENC_PARITY_EN
                                r_parity   <= r_parity ^ r_shreg[MSB];
`endif
                            end else begin
                                r_second <= 1'b0;
                                r_shreg  <= w_shreg_next;
                                if (r_bit_cnt == 5'd0) begin
`ifdef TT_HOENE_MANCHESTER_ENC_PARITY_EN
                                    r_state <= PARITY;
                                    r_out   <= man_first_half(r_parity);
`else
                                    r_state    <= GAP;
                                    r_half_idx <= 5'd0;
                                    r_out      <= 1'b0;
`endif
                                end else begin
                                    r_bit_cnt <= r_bit_cnt - 5'd1;
                                    r_out     <= man_first_half(w_shreg_next[MSB]);
                                end
                            end
                        end
                    end
`ifdef TT_HOENE_MANCHESTER_ENC_PARITY_EN
                    PARITY: begin
                        if (w_tick) begin
                            if (!r_second) begin
                                r_second   <= 1'b1;
                                r_out      <= r_parity;
                                r_out_clk  <= 1'b1;
                                r_out_data <= r_parity;
                            end else begin
                                r_second   <= 1'b0;
                                r_state    <= GAP;
                                r_half_idx <= 5'd0;
                                r_out      <= 1'b0;
                            end
                        end
                    end
`endif
                    GAP: begin
                        if (w_pre_tick && (r_half_idx == LAST_GAP)) begin
                            r_tx_ready <= 1'b1;
                        end
                        if (w_tick) begin
                            if (r_half_idx == LAST_GAP) begin
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_half_idx <= r_half_idx + 5'd1;
                            end
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_out   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tx_if.tx_ready = r_tx_ready;
    assign out            = r_out;
    assign out_clk        = r_out_clk;
    assign out_data       = r_out_data;
    assign busy           = r_busy;
    assign dbg_state      = r_state;
endmodule
